// File: rtl/slot_reel_ctrl.sv
// -----------------------------------------------------------------------------
// slot_reel_ctrl
// Three-reel spin controller. On a rising edge of start (while idle) one LFSR
// word is latched and split into a target symbol per reel. The reels then step
// together on a divided clock. Each reel must complete a staggered minimum
// number of steps and then stops as soon as it shows its target. Once all three
// reels have stopped, a one-cycle done pulse is issued and win/pair are
// reported.
//
// Ports
//   clk     in   system clock
//   reset   in   asynchronous, active-low reset
//   rnd     in   [LFSR_W] random word, sampled only on an accepted start
//   start   in   player spin request (level; rising edge detected here)
//   reel0-2 out  [SYM_W] displayed reel positions
//   busy    out  spin in progress (SPIN and RESULT)
//   done    out  one-cycle pulse when the spin completes
//   win     out  all reels equal, held until the next accepted start
//   pair    out  exactly two reels equal, held until the next accepted start
// -----------------------------------------------------------------------------
module slot_reel_ctrl #(
   parameter int LFSR_W    = 15,
   parameter int SYM_W     = 3,
   parameter int STEP_DIV  = 4,
   parameter int MIN_STEPS = 16,
   parameter int STAGGER   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LFSR_W-1:0] rnd,
   input  logic              start,
   output logic [SYM_W-1:0]  reel0,
   output logic [SYM_W-1:0]  reel1,
   output logic [SYM_W-1:0]  reel2,
   output logic              busy,
   output logic              done,
   output logic              win,
   output logic              pair
);

   // Largest tick index on which a reel can still stop, plus headroom so the
   // counter never wraps even on the final tick of a spin.
   localparam int CNT_MAX = MIN_STEPS + 2 * STAGGER + (1 << SYM_W);
   localparam int CNT_W   = $clog2(CNT_MAX + 2);
   localparam int DIV_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SPIN   = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   state_t                  state_r, state_s;
   logic [2:0][SYM_W-1:0]   reel_r, reel_s;
   logic [2:0][SYM_W-1:0]   tgt_r, tgt_s;
   logic [2:0]              run_r, run_s;
   logic [DIV_W-1:0]        div_r, div_s;
   logic [CNT_W-1:0]        cnt_r, cnt_s;
   logic                    start_q_r;
   logic                    busy_r, busy_s;
   logic                    done_r, done_s;
   logic                    win_r, win_s;
   logic                    pair_r, pair_s;
   logic                    edge_s;
   logic                    tick_s;
   logic                    unused_rnd_s;

   // Outcome classification: {win, pair}; pair excludes the three-equal case.
   function automatic logic [1:0] classify(input logic [SYM_W-1:0] a,
                                           input logic [SYM_W-1:0] b,
                                           input logic [SYM_W-1:0] c);
      logic w;
      logic p;
      w = (a == b) && (b == c);
      p = ((a == b) || (b == c) || (a == c)) && !w;
      return {w, p};
   endfunction

   assign edge_s       = start & ~start_q_r;
   assign unused_rnd_s = ^rnd;

   // Next-state, reel motion and result computation.
   always_comb begin
      state_s = state_r;
      reel_s  = reel_r;
      tgt_s   = tgt_r;
      run_s   = run_r;
      div_s   = div_r;
      cnt_s   = cnt_r;
      win_s   = win_r;
      pair_s  = pair_r;
      tick_s  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (edge_s) begin
               for (int k = 0; k < 3; k++) begin
                  tgt_s[k] = rnd[k*SYM_W +: SYM_W];
               end
               div_s   = '0;
               cnt_s   = '0;
               win_s   = 1'b0;
               pair_s  = 1'b0;
               run_s   = 3'b111;
               state_s = ST_SPIN;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_SPIN: begin
            tick_s = (div_r == DIV_W'(STEP_DIV - 1));
            if (tick_s) begin
               div_s = '0;
               cnt_s = cnt_r + CNT_W'(1'b1);
               for (int k = 0; k < 3; k++) begin
                  if (run_r[k]) begin
                     // Stop only once the staggered minimum is reached and
                     // the reel is already showing its target.
                     if ((cnt_r >= CNT_W'(MIN_STEPS + k * STAGGER)) &&
                         (reel_r[k] == tgt_r[k])) begin
                        run_s[k] = 1'b0;
                     end else begin
                        reel_s[k] = reel_r[k] + SYM_W'(1'b1);
                     end
                  end else begin
                     reel_s[k] = reel_r[k];
                  end
               end
            end else begin
               div_s = div_r + DIV_W'(1'b1);
            end

            // Result is latched on entry to RESULT so it is valid with done.
            if (run_s == 3'b000) begin
               state_s         = ST_RESULT;
               {win_s, pair_s} = classify(reel_s[0], reel_s[1], reel_s[2]);
            end else begin
               state_s = ST_SPIN;
            end
         end

         ST_RESULT: begin
            state_s = ST_IDLE;
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      busy_s = (state_s != ST_IDLE);
      done_s = (state_s == ST_RESULT);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         reel_r    <= '0;
         tgt_r     <= '0;
         run_r     <= 3'b000;
         div_r     <= '0;
         cnt_r     <= '0;
         start_q_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         win_r     <= 1'b0;
         pair_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         reel_r    <= reel_s;
         tgt_r     <= tgt_s;
         run_r     <= run_s;
         div_r     <= div_s;
         cnt_r     <= cnt_s;
         start_q_r <= start;
         busy_r    <= busy_s;
         done_r    <= done_s;
         win_r     <= win_s;
         pair_r    <= pair_s;
      end
   end

   assign reel0 = reel_r[0];
   assign reel1 = reel_r[1];
   assign reel2 = reel_r[2];
   assign busy  = busy_r;
   assign done  = done_r;
   assign win   = win_r;
   assign pair  = pair_r;

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for slot_reel_ctrl. Two instances: dut_a uses a fast configuration
// (STEP_DIV=1, MIN_STEPS=4, STAGGER=2), dut_b the default one (STEP_DIV=4,
// MIN_STEPS=16, STAGGER=8). Inputs are driven and outputs sampled 1 time unit
// after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_slot_reel_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        start_a = 1'b0;
   logic [14:0] rnd_a = 15'd0;
   logic [2:0]  r0_a, r1_a, r2_a;
   logic        busy_a, done_a, win_a, pair_a;

   logic        start_b = 1'b0;
   logic [14:0] rnd_b = 15'd0;
   logic [2:0]  r0_b, r1_b, r2_b;
   logic        busy_b, done_b, win_b, pair_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   slot_reel_ctrl #(.LFSR_W(15), .SYM_W(3), .STEP_DIV(1), .MIN_STEPS(4), .STAGGER(2)) dut_a (
      .clk(clk), .reset(reset), .rnd(rnd_a), .start(start_a),
      .reel0(r0_a), .reel1(r1_a), .reel2(r2_a),
      .busy(busy_a), .done(done_a), .win(win_a), .pair(pair_a)
   );

   slot_reel_ctrl #(.LFSR_W(15), .SYM_W(3), .STEP_DIV(4), .MIN_STEPS(16), .STAGGER(8)) dut_b (
      .clk(clk), .reset(reset), .rnd(rnd_b), .start(start_b),
      .reel0(r0_b), .reel1(r1_b), .reel2(r2_b),
      .busy(busy_b), .done(done_b), .win(win_b), .pair(pair_b)
   );

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Wait for done on dut_a, bounded; cyc = cycles waited.
   task automatic run_a(input int lim, output int cyc);
      cyc = 0;
      do begin
         step(1);
         cyc++;
      end while (!done_a && cyc < lim);
      check("done_a_seen", 32'(done_a), 32'd1);
   endtask

   task automatic run_b(input int lim, output int cyc);
      cyc = 0;
      do begin
         step(1);
         cyc++;
      end while (!done_b && cyc < lim);
      check("done_b_seen", 32'(done_b), 32'd1);
   endtask

   // Reference {win, pair}.
   function automatic logic [1:0] ref_wp(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      logic w;
      w = (a == b) && (a == c);
      return {w, !w && ((a == b) || (a == c) || (b == c))};
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int        cyc;
      int        n_done;
      int        done_cyc;
      int        nchg;
      logic [2:0] prev;
      logic [31:0] r;
      logic [2:0] t0, t1, t2;

      // ---------------- reset state ----------------
      step(2);
      check("rst_reels_a", 32'({r0_a, r1_a, r2_a}), 32'd0);
      check("rst_flags_a", 32'({busy_a, done_a, win_a, pair_a}), 32'd0);
      check("rst_flags_b", 32'({busy_b, done_b, win_b, pair_b}), 32'd0);
      reset = 1'b1;
      step(1);

      // ---------------- win: targets 5,5,5 ----------------
      rnd_a   = 15'h016D;
      start_a = 1'b1;
      step(1);                                   // cycle E+1
      check("win_busy_e1", 32'(busy_a), 32'd1);
      check("win_reels_e1", 32'({r0_a, r1_a, r2_a}), 32'd0);
      start_a = 1'b0;
      for (int c = 2; c <= 16; c++) begin
         step(1);
         case (c)
            5:  check("win_r0_e5", 32'(r0_a), 32'd4);
            6:  check("win_r0_e6", 32'(r0_a), 32'd5);
            10: begin
               check("win_r0_e10", 32'(r0_a), 32'd5);
               check("win_r1_e10", 32'(r1_a), 32'd1);
            end
            14: check("win_done_e14", 32'(done_a), 32'd0);
            15: begin
               check("win_done_e15", 32'(done_a), 32'd1);
               check("win_busy_e15", 32'(busy_a), 32'd1);
               check("win_wp_e15", 32'({win_a, pair_a}), 32'b10);
               check("win_reels_e15", 32'({r0_a, r1_a, r2_a}), 32'({3'd5, 3'd5, 3'd5}));
            end
            16: begin
               check("win_busy_e16", 32'(busy_a), 32'd0);
               check("win_done_e16", 32'(done_a), 32'd0);
               check("win_held_e16", 32'(win_a), 32'd1);
            end
            default: ;
         endcase
      end

      // ---------------- reset mid-spin ----------------
      rnd_a   = 15'h0051;
      start_a = 1'b1;
      step(5);                                   // reels 5 + 4 steps = 1
      check("pre_rst_r0", 32'(r0_a), 32'd1);
      check("pre_rst_busy", 32'(busy_a), 32'd1);
      start_a = 1'b0;
      reset   = 1'b0;
      #1;
      check("rst_mid_reels", 32'({r0_a, r1_a, r2_a}), 32'd0);
      check("rst_mid_flags", 32'({busy_a, done_a, win_a, pair_a}), 32'd0);
      step(2);
      reset = 1'b1;
      step(1);

      // ---------------- pair + ignored starts: targets 1,2,1 ----------------
      start_a  = 1'b1;
      n_done   = 0;
      done_cyc = 0;
      for (int c = 1; c <= 24; c++) begin
         step(1);
         if (done_a) begin
            n_done++;
            done_cyc = c;
         end
         start_a = (c <= 8) ? ((c % 2) == 0) : 1'b1;
      end
      check("pair_ndone", 32'(n_done), 32'd1);
      check("pair_done_cyc", 32'(done_cyc), 32'd12);
      check("pair_reels", 32'({r0_a, r1_a, r2_a}), 32'({3'd1, 3'd2, 3'd1}));
      check("pair_wp", 32'({win_a, pair_a}), 32'b01);
      check("held_no_restart", 32'(busy_a), 32'd0);

      // new edge after low: from 1,2,1 to 5,5,5
      start_a = 1'b0;
      step(1);
      rnd_a   = 15'h016D;
      start_a = 1'b1;
      step(1);
      check("restart_busy", 32'(busy_a), 32'd1);
      check("restart_pair_clr", 32'(pair_a), 32'd0);
      run_a(40, cyc);
      check("restart_done_cyc", 32'(cyc + 1), 32'd14);
      check("restart_reels", 32'({r0_a, r1_a, r2_a}), 32'({3'd5, 3'd5, 3'd5}));
      check("restart_win", 32'(win_a), 32'd1);

      // ---------------- divider and persistence on dut_b ----------------
      rnd_b   = 15'h016D;
      start_b = 1'b1;
      step(1);
      prev = r0_b;
      nchg = 0;
      for (int c = 2; c <= 40; c++) begin
         step(1);
         if (r0_b !== prev) begin
            check("div_phase", 32'((c - 1) % 4), 32'd0);
            nchg++;
            prev = r0_b;
         end
      end
      check("div_nchg", 32'(nchg), 32'd9);
      run_b(200, cyc);
      check("div_done_cyc", 32'(40 + cyc), 32'd153);
      check("div_reels", 32'({r0_b, r1_b, r2_b}), 32'({3'd5, 3'd5, 3'd5}));
      check("div_win", 32'(win_b), 32'd1);

      start_b = 1'b0;
      step(1);
      start_b = 1'b1;
      step(1);
      check("persist_win_clr", 32'(win_b), 32'd0);
      check("persist_busy", 32'(busy_b), 32'd1);
      check("persist_r0_start", 32'(r0_b), 32'd5);
      run_b(200, cyc);
      check("persist_done_cyc", 32'(cyc + 1), 32'd133);
      check("persist_reels", 32'({r0_b, r1_b, r2_b}), 32'({3'd5, 3'd5, 3'd5}));
      check("persist_win", 32'(win_b), 32'd1);
      start_b = 1'b0;

      // ---------------- random regression on dut_a ----------------
      for (int i = 0; i < 1000; i++) begin
         start_a = 1'b0;
         step($urandom_range(3, 1));
         r       = $urandom;
         rnd_a   = r[14:0];
         t0      = r[2:0];
         t1      = r[5:3];
         t2      = r[8:6];
         start_a = 1'b1;
         step(1);
         rnd_a   = ~r[14:0];                     // must not affect the spin
         start_a = ($urandom_range(1, 0) == 1);
         run_a(25, cyc);
         check("rnd_len", 32'(cyc + 1 <= 18), 32'd1);
         check("rnd_reels", 32'({r0_a, r1_a, r2_a}), 32'({t0, t1, t2}));
         check("rnd_wp", 32'({win_a, pair_a}), 32'(ref_wp(t0, t1, t2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
